// File: rtl/irq_onehot_arbiter.sv
// irq_onehot_arbiter: captures rising edges on asynchronous request lines and grants one
// pending line at a time, round-robin, as a strictly one-hot vector with a valid/ack handshake.
module irq_onehot_arbiter #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    input  logic         clr_miss,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic [N-1:0] pending,
    output logic [N-1:0] miss
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                       state_q, state_d;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                 hist_q;
    logic [N-1:0]                 pending_q, pending_d;
    logic [N-1:0]                 miss_q, miss_d;
    logic [N-1:0]                 grant_q, grant_d;
    logic [N-1:0]                 rise, clear;
    logic [IW-1:0]                ptr_q, ptr_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [IW-1:0]                pick, j;
    logic                         found;
    logic [2:0]                   warm_q;
    logic                         armed;

    // Levels already high when reset releases are treated as seen, not as new events:
    // edge detection stays disarmed until hist has caught up with the synchronizer output.
    assign armed = warm_q == 3'(SYNC_STAGES + 1);
    assign rise  = armed ? sync_q[SYNC_STAGES-1] & ~hist_q : '0;
    assign clear = (state_q == GRANT && ack) ? grant_q : '0;

    // A new event on the line being acked wins over the clear and is not a miss.
    assign pending_d = rise | (pending_q & ~clear);
    assign miss_d    = (rise & pending_q & ~clear) | (miss_q & {N{~clr_miss}});

    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = ptr_q + IW'(k);
            if (!found && pending_q[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d       = GRANT;
                grant_d       = '0;
                grant_d[pick] = 1'b1;
                idx_d         = pick;
            end
        end else if (ack) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= '0;
            warm_q    <= '0;
            pending_q <= '0;
            miss_q    <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], req};
            hist_q    <= sync_q[SYNC_STAGES-1];
            warm_q    <= armed ? warm_q : warm_q + 3'd1;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            state_q   <= state_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = state_q == GRANT;
    assign pending     = pending_q;
    assign miss        = miss_q;
endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// tb_irq_onehot_arbiter: per-cycle vector table for latency and round-robin wrap,
// plus hand-written sequences for reset, hold, miss/coincidence and full-load fairness.
module tb_irq_onehot_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       ack = 1'b0;
    logic       clr_miss = 1'b0;
    logic [7:0] grant, pending, miss;
    logic       grant_valid;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       clr;
        logic [7:0] g;
        logic       v;
        logic [7:0] p;
        logic [7:0] m;
    } vec_t;

    vec_t tv[40];
    int   nv = 0;

    irq_onehot_arbiter #(.N(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clr_miss(clr_miss),
        .grant(grant), .grant_valid(grant_valid), .pending(pending), .miss(miss)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] rq, input logic a, input logic c,
                       input logic [7:0] g, input logic v, input logic [7:0] p, input logic [7:0] m);
        tv[nv] = '{r, rq, a, c, g, v, p, m};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_all(input string nm, input logic [7:0] g, input logic v,
                              input logic [7:0] p, input logic [7:0] m);
        chk({nm, ".grant"}, grant, g);
        chk({nm, ".valid"}, {7'b0, grant_valid}, {7'b0, v});
        chk({nm, ".pending"}, pending, p);
        chk({nm, ".miss"}, miss, m);
        chk({nm, ".popcount"}, 8'($countones(grant)), {7'b0, grant_valid});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst_n = 1'b0; req = r; ack = 1'b0; clr_miss = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        // single event on line 5: pending after 3 edges, grant one edge later, ack clears
        add(1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        repeat (3) add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(0, 8'h20, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(0, 8'h20, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(0, 8'h20, 0, 0, 8'h00, 0, 8'h20, 8'h00);
        add(0, 8'h20, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(0, 8'h20, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(0, 8'h20, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        // lines 0 and 7 together, twice: pointer wraps 7 -> 0 so line 0 goes first again
        add(1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        repeat (3) add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int r = 0; r < 2; r++) begin
            add(0, 8'h81, 0, 0, 8'h00, 0, 8'h00, 8'h00);
            add(0, 8'h81, 0, 0, 8'h00, 0, 8'h00, 8'h00);
            add(0, 8'h81, 0, 0, 8'h00, 0, 8'h81, 8'h00);
            add(0, 8'h81, 0, 0, 8'h01, 1, 8'h81, 8'h00);
            add(0, 8'h81, 1, 0, 8'h00, 0, 8'h80, 8'h00);
            add(0, 8'h81, 0, 0, 8'h80, 1, 8'h80, 8'h00);
            add(0, 8'h81, 1, 0, 8'h00, 0, 8'h00, 8'h00);
            if (r == 0) repeat (3) add(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        end

        // reset with all requests high: those levels never become events
        rst_n = 1'b0; req = 8'hFF;
        cyc(2);
        expect_all("rst_hold", 8'h00, 0, 8'h00, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            expect_all("idle_level", 8'h00, 0, 8'h00, 8'h00);
        end

        for (int i = 0; i < nv; i++) begin
            rst_n = !tv[i].rst; req = tv[i].req; ack = tv[i].ack; clr_miss = tv[i].clr;
            cyc(1);
            rst_n = 1'b1;
            expect_all($sformatf("vec%0d", i), tv[i].g, tv[i].v, tv[i].p, tv[i].m);
        end
        ack = 1'b0; req = 8'h00;

        // hold under load: grant for line 2 is stable while lines 1 and 6 arrive
        do_reset(8'h00);
        req = 8'h04;
        cyc(4);
        expect_all("hold_start", 8'h04, 1, 8'h04, 8'h00);
        req = 8'h46;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("hold_grant", grant, 8'h04);
        end
        expect_all("hold_pend", 8'h04, 1, 8'h46, 8'h00);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        expect_all("hold_ack", 8'h00, 0, 8'h42, 8'h00);
        cyc(1);
        expect_all("hold_next", 8'h40, 1, 8'h42, 8'h00);

        // miss, ack/rise coincidence, clr_miss vs new miss
        do_reset(8'h00);
        req = 8'h04;
        cyc(4);
        expect_all("miss_grant", 8'h04, 1, 8'h04, 8'h00);
        req = 8'h00; cyc(3);
        req = 8'h04; cyc(3);
        expect_all("miss_set", 8'h04, 1, 8'h04, 8'h04);
        clr_miss = 1'b1; cyc(1); clr_miss = 1'b0;
        expect_all("miss_clr", 8'h04, 1, 8'h04, 8'h00);
        req = 8'h00; cyc(3);
        req = 8'h04; cyc(2);
        ack = 1'b1; cyc(1); ack = 1'b0;
        expect_all("coinc", 8'h00, 0, 8'h04, 8'h00);
        cyc(1);
        expect_all("coinc_regrant", 8'h04, 1, 8'h04, 8'h00);
        req = 8'h00; cyc(3);
        req = 8'h04; cyc(2);
        clr_miss = 1'b1; cyc(1); clr_miss = 1'b0;
        expect_all("clr_vs_set", 8'h04, 1, 8'h04, 8'h04);
        clr_miss = 1'b1; cyc(1); clr_miss = 1'b0;
        chk("clr_again", miss, 8'h00);
        ack = 1'b1; cyc(1); ack = 1'b0;
        expect_all("miss_done", 8'h00, 0, 8'h00, 8'h00);

        // all eight pending: each line exactly once, in index order from ptr=0
        do_reset(8'h00);
        req = 8'hFF;
        cyc(3);
        chk("all_pend", pending, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            e = 8'h01 << k;
            cyc(1);
            chk($sformatf("rr_grant%0d", k), grant, e);
            chk("rr_valid", {7'b0, grant_valid}, 8'h01);
            ack = 1'b1; cyc(1); ack = 1'b0;
            chk("rr_drop", grant, 8'h00);
        end
        expect_all("rr_done", 8'h00, 0, 8'h00, 8'h00);

        // asynchronous reset mid-grant drops everything at once
        do_reset(8'h00);
        req = 8'hF0;
        cyc(3);
        cyc(1);
        expect_all("mid_before", 8'h10, 1, 8'hF0, 8'h00);
        #3 rst_n = 1'b0;
        #1 expect_all("mid_async", 8'h00, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            expect_all("mid_after", 8'h00, 0, 8'h00, 8'h00);
        end
        req = 8'h00; cyc(3);
        req = 8'h20; cyc(4);
        expect_all("mid_new", 8'h20, 1, 8'h20, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_onehot_arbiter.md
Name: irq_onehot_arbiter

Overview:
- Upstream request stage for the 8-to-3 encoder path.
- Captures rising edges on eight asynchronous request lines into a pending register.
- Selects one pending line round-robin and presents it as a strictly one-hot grant vector with a valid/ack handshake.
- The downstream 8x3 encoder converts the grant to a binary index. This block guarantees the encoder only ever sees all-zero or exactly-one-hot input.

Parameters:
- N, 8, number of request lines; fixed at 8 to match the downstream encoder; other values unsupported.
- SYNC_STAGES, 2, synchronizer flops per request line; legal range 2..3.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; async assert, sync deassert handled at top level.
- req  input  8  asynchronous level request lines; a 0->1 transition is one event.
- ack  input  1  consumer accepts the current grant; sampled only while grant_valid=1.
- clr_miss  input  1  single-cycle pulse; clears all miss flags.
- grant  output  8  one-hot granted line; all zeros when grant_valid=0.
- grant_valid  output  1  grant holds a valid one-hot value.
- pending  output  8  registered pending events not yet granted and acked.
- miss  output  8  sticky per-line flag; an event arrived while that line was already pending.

Behaviour:
Reset:
- rst_n=0 immediately clears synchronizers, edge-history register, pending, miss, grant, grant_valid, and round-robin pointer ptr (ptr=0).
- State returns to IDLE.
- Reset mid-grant drops the grant and all pending events; nothing is retained.

Capture:
- Each req bit passes through SYNC_STAGES flops, then a history flop.
- rise[i] = sync_last[i] & ~hist[i].
- A req rising before edge 0 sets pending[i] at edge SYNC_STAGES, i.e. edge 2 at default. Latency from req to pending = SYNC_STAGES+1 edges counting edge 0.
- A level held high produces exactly one event. It must fall for at least one sampled cycle before it can re-trigger.

FSM (registered outputs):
- IDLE:
  - If pending != 0: choose the first set bit scanning indices ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: grant <= onehot(idx), grant_valid <= 1, state <= GRANT.
  - If pending == 0: stay in IDLE; grant=0, grant_valid=0.
  - ack in IDLE is ignored.
- GRANT:
  - grant and grant_valid are held stable until ack.
  - New events may set other pending bits meanwhile; they do not change grant.
  - ack=1 at an edge: pending[idx] cleared, ptr <= (idx+1) mod 8, grant <= 0, grant_valid <= 0, state <= IDLE.
- There is always at least one IDLE cycle between consecutive grants, so the grant drops to zero between any two grants.

Boundary conditions:
- rise[idx] in the same cycle as ack for idx: clear and set coincide; set wins. pending[idx] stays 1 as a new event, and miss is not set.
- rise[i] while pending[i]=1 and not being cleared that cycle: pending unchanged, miss[i] <= 1.
- clr_miss coincident with a new miss on the same line: set wins, so miss[i]=1.
- All eight lines pending: served in order ptr..ptr+7. Each line is granted exactly once per eight grants.
- ptr wraps 7 -> 0.
- grant is never multi-hot. grant_valid=1 implies grant is one-hot (popcount = 1).

Test Plan:
- Reset then idle: rst_n=0 with req=8'hFF, release, req held constant → no events, pending=0, grant=0, grant_valid=0 throughout.
- Single event latency: req[5] 0->1 before edge 0 → pending=8'h20 after edge 2; grant=8'h20, valid=1 after edge 3; ack at edge 5 → grant=0, pending=0 after edge 5; ptr=6.
- Round-robin fairness: from reset, raise req=8'h81 together, ack every grant one cycle after valid → grants 8'h01 then 8'h80. Re-pulse req[0] and req[7] → grant 8'h01 first (ptr=0 after wrap from 7).
- Hold under load: while grant=8'h04 waits 10 cycles without ack, pulse req[1] and req[6] → grant stays 8'h04; pending=8'h46; after ack, next grant=8'h40 (ptr=3 scan).
- Miss and coincidence: pulse req[2] twice before ack → miss=8'h04. Pulse req[2] in the same cycle as ack of line 2 → pending[2] remains 1, no new miss. clr_miss → miss=0.
- Reset mid-operation: grant_valid=1, pending=8'hF0, assert rst_n=0 between edges → all outputs 0 immediately, no grant after release until a new rising req.
